// File: rtl/joltage_solver_k.sv
// Streaming K-digit line solver. For each newline-terminated line it keeps,
// for every length j, the largest j-digit subsequence seen so far, reports
// the K-digit winner per line and accumulates it into a running total.

// One length-j slot: extend the best (j-1)-digit prefix by the new digit
// and keep the larger of that candidate and the current best j-digit value.
module joltage_slot #(
    parameter int VAL_W = 8
) (
    input  logic [VAL_W-1:0] prev_i,
    input  logic [VAL_W-1:0] cur_i,
    input  logic [3:0]       d_i,
    input  logic             elig_i,
    output logic [VAL_W-1:0] next_o
);
    logic [VAL_W-1:0] cand;

    // candidate = prev*10 + d, with *10 as two shifts and an add
    always_comb begin
        cand   = (prev_i << 3) + (prev_i << 1) + VAL_W'(d_i);
        next_o = (elig_i && (cand > cur_i)) ? cand : cur_i;
    end
endmodule

module joltage_solver_k #(
    parameter int  K     = 12,
    parameter int  ACC_W = 64,
    localparam int VAL_W = 4 * K
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [VAL_W-1:0] line_value,
    output logic             line_short,
    output logic             line_valid,
    input  logic             line_ready,
    output logic [ACC_W-1:0] total,
    output logic [31:0]      line_count,
    output logic             overflow
);
    localparam int CW = $clog2(K + 1);

    typedef enum logic [0:0] {COLLECT, PENDING} state_t;

    state_t                      state_q, state_d;
    logic [K-1:0][VAL_W-1:0]     best_q, best_d, best_nx;
    logic [CW-1:0]               dcnt_q, dcnt_d;
    logic [VAL_W-1:0]            val_q, val_d;
    logic                        short_q, short_d;
    logic [ACC_W-1:0]            total_q, total_d;
    logic [31:0]                 cnt_q, cnt_d;
    logic                        ovf_q, ovf_d;
    logic [ACC_W:0]              sum;
    logic                        accept, is_digit, is_nl, result;

    assign line_valid = (state_q == PENDING);
    assign ready_out  = !line_valid || line_ready;
    assign accept     = valid_in && ready_out;
    assign is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign is_nl      = (char_in == 8'h0A);
    // a newline on an empty line (blank or CRLF tail) produces nothing
    assign result     = accept && is_nl && (dcnt_q != '0);
    assign sum        = {1'b0, total_q} + (ACC_W + 1)'(best_q[K-1]);

    assign line_value = val_q;
    assign line_short = short_q;
    assign total      = total_q;
    assign line_count = cnt_q;
    assign overflow   = ovf_q;

    // slot j (0-based) holds the best (j+1)-digit value; slot 0 extends zero
    for (genvar j = 0; j < K; j++) begin : g_slot
        localparam logic [CW-1:0] JV = CW'(j);
        logic [VAL_W-1:0] prev;
        if (j == 0) begin : g_first
            assign prev = '0;
        end else begin : g_rest
            assign prev = best_q[j-1];
        end
        joltage_slot #(.VAL_W(VAL_W)) u_slot (
            .prev_i (prev),
            .cur_i  (best_q[j]),
            .d_i    (char_in[3:0]),
            .elig_i (dcnt_q >= JV),
            .next_o (best_nx[j])
        );
    end

    // result-pending FSM: a concurrent result keeps PENDING with new data
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (result) state_d = PENDING;
            PENDING: if (line_ready && !result) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // per-line digit tracking and result / total update
    always_comb begin
        best_d  = best_q;
        dcnt_d  = dcnt_q;
        val_d   = val_q;
        short_d = short_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (accept && is_digit) begin
            best_d = best_nx;
            if (dcnt_q != CW'(K)) dcnt_d = dcnt_q + CW'(1);
        end
        if (result) begin
            if (dcnt_q == CW'(K)) begin
                val_d   = best_q[K-1];
                short_d = 1'b0;
                total_d = sum[ACC_W-1:0];
                ovf_d   = ovf_q | sum[ACC_W];
            end else begin
                val_d   = '0;
                short_d = 1'b1;
            end
            cnt_d  = cnt_q + 32'd1;
            best_d = '0;
            dcnt_d = '0;
        end
    end

    // state registers, async active-high clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            best_q  <= '0;
            dcnt_q  <= '0;
            val_q   <= '0;
            short_q <= 1'b0;
            total_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            best_q  <= best_d;
            dcnt_q  <= dcnt_d;
            val_q   <= val_d;
            short_q <= short_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_joltage_solver_k.sv
// Bench for joltage_solver_k: three instances (K=2/64b, K=12/64b, K=2/8b)
// share one byte stream and are checked against a greedy reference model.
module tb_joltage_solver_k;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] char_in;
    logic valid_in;
    logic line_ready;

    logic ra, rb, rc, lva, lvb, lvc, lsa, lsb, lsc, oa, ob, oc;
    logic [7:0]  va, vc, tc;
    logic [47:0] vb;
    logic [63:0] ta, tb;
    logic [31:0] ca, cb, cc;

    always #5 clk = ~clk;

    joltage_solver_k #(.K(2), .ACC_W(64)) u_a (
        .clk(clk), .reset(reset), .char_in(char_in), .valid_in(valid_in),
        .ready_out(ra), .line_value(va), .line_short(lsa), .line_valid(lva),
        .line_ready(line_ready), .total(ta), .line_count(ca), .overflow(oa));
    joltage_solver_k #(.K(12), .ACC_W(64)) u_b (
        .clk(clk), .reset(reset), .char_in(char_in), .valid_in(valid_in),
        .ready_out(rb), .line_value(vb), .line_short(lsb), .line_valid(lvb),
        .line_ready(line_ready), .total(tb), .line_count(cb), .overflow(ob));
    joltage_solver_k #(.K(2), .ACC_W(8)) u_c (
        .clk(clk), .reset(reset), .char_in(char_in), .valid_in(valid_in),
        .ready_out(rc), .line_value(vc), .line_short(lsc), .line_valid(lvc),
        .line_ready(line_ready), .total(tc), .line_count(cc), .overflow(oc));

    logic [63:0] av[3], at[3];
    logic        ar[3], alv[3], als[3], ao[3];
    logic [31:0] ac[3];
    assign av[0] = {56'b0, va};  assign av[1] = {16'b0, vb}; assign av[2] = {56'b0, vc};
    assign at[0] = ta;           assign at[1] = tb;          assign at[2] = {56'b0, tc};
    assign ar[0] = ra;  assign ar[1] = rb;  assign ar[2] = rc;
    assign alv[0] = lva; assign alv[1] = lvb; assign alv[2] = lvc;
    assign als[0] = lsa; assign als[1] = lsb; assign als[2] = lsc;
    assign ao[0] = oa;  assign ao[1] = ob;  assign ao[2] = oc;
    assign ac[0] = ca;  assign ac[1] = cb;  assign ac[2] = cc;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int               kk[3] = '{2, 12, 2};
    int               aw[3] = '{64, 64, 8};
    int               cur[$];
    longint unsigned  exp_val[3], exp_tot[3];
    bit               exp_short[3], exp_ovf[3];
    int unsigned      exp_cnt;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // largest k-digit subsequence by greedy window selection
    function automatic longint unsigned best_of(input int d[$], input int k);
        longint unsigned v = 0;
        int start = 0;
        for (int i = 0; i < k; i++) begin
            int bi = start;
            for (int p = start; p <= d.size() - (k - i); p++)
                if (d[p] > d[bi]) bi = p;
            v = v * 10 + longint'(d[bi]);
            start = bi + 1;
        end
        return v;
    endfunction

    task automatic model_reset();
        cur.delete();
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            exp_val[i] = 0; exp_tot[i] = 0; exp_short[i] = 0; exp_ovf[i] = 0;
        end
    endtask

    task automatic model_accept(input byte c, output bit res);
        res = 0;
        if (c >= 8'h30 && c <= 8'h39) cur.push_back(int'(c) - 48);
        else if (c == 8'h0A && cur.size() > 0) begin
            res = 1;
            for (int i = 0; i < 3; i++) begin
                if (cur.size() >= kk[i]) begin
                    logic [64:0] s;
                    exp_val[i] = best_of(cur, kk[i]);
                    exp_short[i] = 0;
                    s = {1'b0, exp_tot[i]} + {1'b0, exp_val[i]};
                    if (aw[i] == 64) begin
                        if (s[64]) exp_ovf[i] = 1;
                        exp_tot[i] = s[63:0];
                    end else begin
                        if ((s[63:0] >> aw[i]) != 0) exp_ovf[i] = 1;
                        exp_tot[i] = s[63:0] & ((64'd1 << aw[i]) - 1);
                    end
                end else begin
                    exp_val[i] = 0;
                    exp_short[i] = 1;
                end
            end
            exp_cnt++;
            cur.delete();
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("value%0d", i), av[i], exp_val[i]);
            chk($sformatf("short%0d", i), als[i], exp_short[i]);
            chk($sformatf("total%0d", i), at[i], exp_tot[i]);
            chk($sformatf("ovf%0d", i), ao[i], exp_ovf[i]);
            chk($sformatf("count%0d", i), ac[i], exp_cnt);
            chk($sformatf("lvalid%0d", i), alv[i], 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ready%0d", tag, i), ar[i], 1);
            chk($sformatf("%s_lvalid%0d", tag, i), alv[i], 0);
            chk($sformatf("%s_value%0d", tag, i), av[i], 0);
            chk($sformatf("%s_short%0d", tag, i), als[i], 0);
            chk($sformatf("%s_total%0d", tag, i), at[i], 0);
            chk($sformatf("%s_count%0d", tag, i), ac[i], 0);
            chk($sformatf("%s_ovf%0d", tag, i), ao[i], 0);
        end
    endtask

    // one byte per cycle; caller guarantees the block is ready
    task automatic send(input byte c);
        bit r;
        @(negedge clk);
        char_in = c; valid_in = 1;
        chk("ready_before_byte", ra & rb & rc, 1);
        @(posedge clk); #1;
        valid_in = 0;
        model_accept(c, r);
        if (r) check_all();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    typedef struct {
        string           s;
        longint unsigned e2;
        longint unsigned e12;
        bit              sh12;
    } vec_t;

    initial begin
        vec_t vt[5];
        bit r;
        vt[0] = '{"987654321111111\n", 98, 64'd987654321111, 0};
        vt[1] = '{"811111111111119\n", 89, 64'd811111111119, 0};
        vt[2] = '{"234234234234278\n", 78, 64'd434234234278, 0};
        vt[3] = '{"818181911112111\n", 92, 64'd888911112111, 0};
        vt[4] = '{"12345\n",           45, 0,                1};

        reset = 1; valid_in = 0; char_in = 8'h00; line_ready = 1;
        model_reset();
        #2 check_reset_outputs("init");
        @(negedge clk); reset = 0;

        // table-driven lines
        for (int i = 0; i < 5; i++) begin
            if (i == 4) do_reset();
            send_str(vt[i].s);
            chk($sformatf("tbl%0d_k2", i), va, vt[i].e2);
            chk($sformatf("tbl%0d_k12", i), vb, vt[i].e12);
            chk($sformatf("tbl%0d_short12", i), lsb, vt[i].sh12);
            if (i == 3) begin
                chk("sum_k2", ta, 357);
                chk("sum_k12", tb, 64'd3121910778619);
                chk("count4", ca, 4);
                chk("ovf_k12", ob, 0);
            end
        end
        chk("short_total", tb, 0);
        send_str("\r\n");
        chk("blank_count", cb, 1);
        chk("blank_total", tb, 0);

        // backpressure: result held, next byte stalled until handshake
        do_reset();
        line_ready = 0;
        send_str("91\n");
        chk("stall_ready_drop", ra, 0);
        @(negedge clk);
        char_in = "4"; valid_in = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_ready", ra, 0);
            chk("stall_value", va, 91);
            chk("stall_lvalid", lva, 1);
        end
        line_ready = 1;
        #1 chk("handshake_ready", ra, 1);
        @(posedge clk); #1;
        valid_in = 0;
        model_accept("4", r);
        chk("handshake_clear", lva, 0);
        @(negedge clk); line_ready = 0;
        send_str("5\n");
        chk("stall_v2", va, 45);
        chk("stall_total", ta, 136);
        line_ready = 1;

        // 8-bit total wraps with sticky overflow
        do_reset();
        send_str("99\n"); chk("ov_t1", tc, 99);  chk("ov_f1", oc, 0);
        send_str("99\n"); chk("ov_t2", tc, 198); chk("ov_f2", oc, 0);
        send_str("99\n"); chk("ov_t3", tc, 41);  chk("ov_f3", oc, 1);
        send_str("10\n"); chk("ov_t4", tc, 51);  chk("ov_sticky", oc, 1);

        // reset mid-line discards partial line
        send_str("98");
        @(negedge clk); reset = 1;
        #1 check_reset_outputs("midline");
        @(negedge clk); reset = 0;
        model_reset();
        send_str("12\n");
        chk("post_rst_val", va, 12);
        chk("post_rst_total", ta, 12);
        chk("post_rst_count", ca, 1);

        // random lines against the reference model
        do_reset();
        for (int l = 0; l < 60; l++) begin
            int len = $urandom_range(0, 18);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 19) == 0) send("x");
                send(byte'(8'h30 + $urandom_range(0, 9)));
            end
            if ($urandom_range(0, 9) == 0) send(8'h0D);
            send(8'h0A);
        end
        chk("rand_count", ca, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/joltage_solver_k.md
# joltage_solver_k

Streaming line solver that, for each newline-terminated line of ASCII digits, selects K digits in original order to form the largest possible K-digit number. It emits that number per line over a valid/ready handshake and adds it into a running total. It sits directly after the byte source in the day-3 datapath and generalises the fixed two-digit solver to any K, with backpressure, per-line result reporting and overflow detection.

## Interface

- K, default 12: digits selected per line; legal range 1..16.
- ACC_W, default 64: width of the running total.
- VAL_W = 4*K (localparam, not overridable): width of the per-line value; 10^K < 16^K, so it always fits.

Ports:

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all state.
- char_in  in  8  ASCII byte.
- valid_in  in  1  char_in is valid this cycle.
- ready_out  out  1  block accepts char_in this cycle.
- line_value  out  VAL_W  best K-digit value of the last completed line.
- line_short  out  1  the last completed line had fewer than K digits.
- line_valid  out  1  line_value / line_short hold a pending result.
- line_ready  in  1  consumer accepts the result.
- total  out  ACC_W  sum of all line_value results, modulo 2^ACC_W.
- line_count  out  32  number of results produced, wrapping.
- overflow  out  1  sticky; set when any addition into total carries out.

## Operation

- A byte is accepted on a rising edge when valid_in && ready_out.
- ready_out = !line_valid || line_ready. It is combinational and stalls every byte, not only newlines.
- Per-line state:
  - best[1..K], each VAL_W wide.
  - dcnt, a digit counter that saturates at K.
- Accepted digit d ('0'..'9'), for every j in 1..K in parallel, using pre-edge values:
  - cand_j = best[j-1]*10 + d, with best[0] ≡ 0.
  - cand_j is eligible only if dcnt >= j-1.
  - best[j] <= max(best[j], cand_j) when eligible.
  - dcnt <= min(dcnt+1, K).
  - ×10 is implemented as (x<<3)+(x<<1), truncated to VAL_W.
- Accepted newline (0x0A) with dcnt == 0: ignored. No result and no count change, so blank lines and CRLF tails are harmless.
- Accepted newline with dcnt > 0:
  - If dcnt == K: line_value <= best[K], line_short <= 0, total <= total + best[K].
  - If dcnt < K: line_value <= 0, line_short <= 1, total unchanged.
  - In both cases: line_valid <= 1, line_count <= line_count+1, and best[*] and dcnt clear.
- overflow is set when the total addition carries out of ACC_W. It is cleared only by reset.
- Any other accepted byte (including 0x0D) is consumed with no effect.
- line_valid clears on a line_valid && line_ready edge, unless a new result is loaded on the same edge, in which case it stays 1 with the new data.
- States:
  - COLLECT (line_valid = 0) goes to PENDING on a newline that produces a result.
  - PENDING goes to COLLECT on a line_ready handshake with no concurrent result.
  - PENDING stays in PENDING on a handshake plus a concurrent result.

## Timing

- Reset values: ready_out = 1, line_valid = 0, line_value = 0, line_short = 0, total = 0, line_count = 0, overflow = 0, best[*] = 0, dcnt = 0.
- Digit update: 1 cycle; best[] reflects a digit on the edge that accepts it.
- Result latency: line_valid, line_value, total and line_count all update on the edge that accepts the newline.
- Back-to-back lines:
  - With line_ready held high, one result per newline, with no bubble.
  - With line_ready low, the block stalls on the first byte after a result until the handshake.
- Reset mid-line or mid-PENDING: the partial line and any pending result are discarded, and all outputs return to reset values asynchronously.
- Inputs are sampled only at rising edges; char_in is ignored while valid_in = 0.

## Test plan

- K=2, lines "987654321111111", "811111111111119", "234234234234278", "818181911112111" (each with newline), line_ready=1:
  - Results 98, 89, 78, 92.
  - total = 357, line_count = 4.
- K=12, same four lines:
  - Results 987654321111, 811111111119, 434234234278, 888911112111.
  - total = 3121910778619, overflow = 0.
- K=12, "12345\n" then "\r\n":
  - One result with line_value = 0, line_short = 1.
  - total unchanged, line_count = 1; the blank line produces nothing.
- K=2, line_ready=0, stream "91\n45\n":
  - line_value = 91 is pending and ready_out drops from the cycle after the first newline.
  - '4' is held until line_ready pulses; then the result 45 is produced and total = 136.
- K=2, ACC_W=8, "99\n" ×3:
  - total goes 99, 198, 41.
  - overflow sets on the third line and stays 1.
- K=2, "98" then reset asserted mid-line, then "12\n":
  - All outputs read 0 during reset.
  - After reset, a single result of 12 with total = 12 and line_count = 1.
